key_entry: RTL and testbench

Sits directly downstream of the 4x4 keypad scanner. It consumes the scanner's 4-bit key code and 3-bit key-press counter, and detects each new key press. Key presses are assembled into two BCD operands plus an operator, which are issued to the ALU stage over a valid/ready handshake. It also drives a BCD display bus that shows the operand currently being edited.

---
 rtl/key_entry.sv | 182 ++++++++++++++++++
 tb/tb_key_entry.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/key_entry.sv
// Key-press assembler: turns scanner key events into two BCD operands plus an operator for the ALU stage.
// Optional KEY_SYNC_EN: two-flop input synchroniser (3-edge latency) instead of one register stage (2-edge).
module key_entry #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            key_code,
    input  logic [2:0]            key_count,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   op_a,
    output logic [4*DIGITS-1:0]   op_b,
    output logic [1:0]            op_sel,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic [1:0]            entry_state,
    output logic                  ovf
);
    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    localparam logic [3:0] K_A = 4'hA;
    localparam logic [3:0] K_B = 4'hB;
    localparam logic [3:0] K_C = 4'hC;
    localparam logic [3:0] K_D = 4'hD;
    localparam logic [3:0] K_E = 4'hE;
    localparam logic [3:0] K_F = 4'hF;

    typedef enum logic [1:0] {
        S_OPA   = 2'd0,
        S_OPB   = 2'd1,
        S_ISSUE = 2'd2
    } state_e;

    logic [3:0] code_sync;
    logic [2:0] cnt_sync;

    // Capture stages are deliberately not reset, so they track the scanner through reset
    // and priming sees the true count.
`ifdef KEY_SYNC_EN
    logic [3:0] code_s1_q, code_s2_q;
    logic [2:0] cnt_s1_q, cnt_s2_q;
    always_ff @(posedge clk) begin
        code_s1_q <= key_code;
        cnt_s1_q  <= key_count;
        code_s2_q <= code_s1_q;
        cnt_s2_q  <= cnt_s1_q;
    end
    assign code_sync = code_s2_q;
    assign cnt_sync  = cnt_s2_q;
`else
    logic [3:0] code_s1_q;
    logic [2:0] cnt_s1_q;
    always_ff @(posedge clk) begin
        code_s1_q <= key_code;
        cnt_s1_q  <= key_count;
    end
    assign code_sync = code_s1_q;
    assign cnt_sync  = cnt_s1_q;
`endif

    state_e         state_q, state_d;
    logic [W-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0]     sel_q, sel_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d, valid_q, valid_d, primed_q, primed_d;
    logic [2:0]     last_cnt_q, last_cnt_d;
    logic           key_ev;
    logic [W-1:0]   cur_op, shifted;
    logic [1:0]     key_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OPA;
            op_a_q     <= '0;
            op_b_q     <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            primed_q   <= 1'b0;
            last_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            primed_q   <= primed_d;
            last_cnt_q <= last_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        primed_d   = primed_q;
        last_cnt_d = last_cnt_q;
        key_ev     = 1'b0;
        cur_op     = (state_q == S_OPA) ? op_a_q : op_b_q;
        shifted    = {cur_op[W-5:0], code_sync};

        unique case (code_sync)
            K_B:     key_sel = 2'b01;
            K_D:     key_sel = 2'b10;
            K_E:     key_sel = 2'b11;
            default: key_sel = 2'b00;
        endcase

        if (!primed_q) begin
            primed_d   = 1'b1;
            last_cnt_d = cnt_sync;
        end else if (cnt_sync != last_cnt_q) begin
            key_ev     = 1'b1;
            last_cnt_d = cnt_sync;
        end

        if (state_q == S_ISSUE && valid_q && out_ready) begin
            valid_d = 1'b0;
            op_a_d  = '0;
            op_b_d  = '0;
            cnt_d   = '0;
            state_d = S_OPA;
        end

        // A clear on the transfer edge overrides the transfer result, including ovf.
        if (key_ev) begin
            if (code_sync == K_C) begin
                op_a_d  = '0;
                op_b_d  = '0;
                sel_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                valid_d = 1'b0;
                state_d = S_OPA;
            end else if (state_q != S_ISSUE) begin
                if (code_sync < 4'd10) begin
                    if (code_sync == 4'd0 && cur_op == '0 && cnt_q == '0) begin
                        cnt_d = cnt_q;
                    end else if (cnt_q == CW'(DIGITS)) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                        if (state_q == S_OPA) op_a_d = shifted;
                        else                  op_b_d = shifted;
                    end
                end else if (code_sync == K_F) begin
                    if (state_q == S_OPB) begin
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                    end
                end else if (code_sync == K_A || code_sync == K_B ||
                             code_sync == K_D || code_sync == K_E) begin
                    if (state_q == S_OPA) begin
                        sel_d   = key_sel;
                        op_b_d  = '0;
                        cnt_d   = '0;
                        state_d = S_OPB;
                    end else if (cnt_q == '0) begin
                        sel_d = key_sel;
                    end
                end
            end
        end
    end

    assign out_valid   = valid_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign op_sel      = sel_q;
    assign disp_bcd    = (state_q == S_OPA) ? op_a_q : op_b_q;
    assign entry_state = state_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_key_entry.sv
// Directed bench for key_entry: vector table of key presses plus hand sequences for
// reset priming, latency, count wrap, clear-on-transfer and reset mid-issue.
module tb_key_entry;
    localparam int unsigned DIGITS = 4;
`ifdef KEY_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_code = 4'h1;
    logic [2:0]  key_count = 3'd5;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] op_a, op_b, disp_bcd;
    logic [1:0]  op_sel, entry_state;
    logic        ovf;

    key_entry #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_count(key_count),
        .out_ready(out_ready), .out_valid(out_valid), .op_a(op_a), .op_b(op_b),
        .op_sel(op_sel), .disp_bcd(disp_bcd), .entry_state(entry_state), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        press;
        logic [3:0]  code;
        logic        rdy;
        logic        hold;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  sel;
        logic [1:0]  st;
        logic        v;
        logic        o;
    } vec_t;

    vec_t       tbl[$];
    int         total = 0;
    int         bad = 0;
    logic [2:0] kc = 3'd5;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [1:0] sel, input logic [1:0] st, input logic v,
                             input logic o);
        chk({tag, ".op_a"}, 32'(op_a), 32'(a));
        chk({tag, ".op_b"}, 32'(op_b), 32'(b));
        chk({tag, ".op_sel"}, 32'(op_sel), 32'(sel));
        chk({tag, ".state"}, 32'(entry_state), 32'(st));
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".ovf"}, 32'(ovf), 32'(o));
        chk({tag, ".disp"}, 32'(disp_bcd), (st == 2'd0) ? 32'(a) : 32'(b));
    endtask

    task automatic press(input logic [3:0] c);
        key_code  = c;
        kc        = kc + 3'd1;
        key_count = kc;
        repeat (LAT + 2) tick();
    endtask

    task automatic apply(input int unsigned idx, input vec_t e);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (e.press) begin
            key_code  = e.code;
            kc        = kc + 3'd1;
            key_count = kc;
        end
        out_ready = e.rdy;
        if (e.rdy) begin
            tick();
            chk({tag, ".xfer_edge_valid"}, 32'(out_valid), 32'd0);
        end
        repeat (LAT + 1) tick();
        out_ready = 1'b0;
        check_all(tag, e.a, e.b, e.sel, e.st, e.v, e.o);
        if (e.hold) begin
            for (int unsigned i = 0; i < 10; i++) begin
                tick();
                chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, ".hold_b"}, 32'(op_b), 32'(e.b));
            end
        end
    endtask

    initial begin
        //              press code  rdy  hold  a         b         sel   st    v     o
        tbl.push_back('{1'b1, 4'h1, 1'b0, 1'b0, 16'h0001, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h2, 1'b0, 1'b0, 16'h0012, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 1'b0, 1'b0, 16'h0012, 16'h0000, 2'd0, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h3, 1'b0, 1'b0, 16'h0012, 16'h0003, 2'd0, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h4, 1'b0, 1'b0, 16'h0012, 16'h0034, 2'd0, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 1'b1, 16'h0012, 16'h0034, 2'd0, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h1, 1'b0, 1'b0, 16'h0001, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h2, 1'b0, 1'b0, 16'h0012, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h3, 1'b0, 1'b0, 16'h0123, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h4, 1'b0, 1'b0, 16'h1234, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h5, 1'b0, 1'b0, 16'h1234, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hC, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h7, 1'b0, 1'b0, 16'h0007, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hA, 1'b0, 1'b0, 16'h0007, 16'h0000, 2'd0, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hB, 1'b0, 1'b0, 16'h0007, 16'h0000, 2'd1, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h9, 1'b0, 1'b0, 16'h0007, 16'h0009, 2'd1, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hD, 1'b0, 1'b0, 16'h0007, 16'h0009, 2'd1, 2'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 1'b0, 16'h0007, 16'h0009, 2'd1, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 4'h5, 1'b0, 1'b0, 16'h0007, 16'h0009, 2'd1, 2'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'h5, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'd1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h9, 1'b0, 1'b0, 16'h0009, 16'h0000, 2'd1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h8, 1'b0, 1'b0, 16'h0098, 16'h0000, 2'd1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h7, 1'b0, 1'b0, 16'h0987, 16'h0000, 2'd1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h6, 1'b0, 1'b0, 16'h9876, 16'h0000, 2'd1, 2'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'h5, 1'b0, 1'b0, 16'h9876, 16'h0000, 2'd1, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hE, 1'b0, 1'b0, 16'h9876, 16'h0000, 2'd3, 2'd1, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 1'b0, 16'h9876, 16'h0000, 2'd3, 2'd2, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 1'b0, 16'h0000, 16'h0000, 2'd3, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd3, 2'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 4'hC, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'd0, 2'd0, 1'b0, 1'b0});

        // Reset with a nonzero scanner count and a digit code present.
        repeat (3) tick();
        check_all("reset", 16'h0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (5) tick();
        check_all("prime", 16'h0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);

        for (int unsigned i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // Count wrap 6->7->0, edge-exact latency, and a multi-step jump.
        key_code = 4'hC; kc = 3'd6; key_count = kc;
        repeat (LAT + 1) tick();
        key_code = 4'h3; kc = 3'd7; key_count = kc;
        repeat (LAT - 1) tick();
        chk("lat_before", 32'(op_a), 32'h0);
        tick();
        chk("lat_at", 32'(op_a), 32'h3);
        key_code = 4'h4; kc = 3'd0; key_count = kc;
        repeat (LAT + 1) tick();
        chk("wrap_op_a", 32'(op_a), 32'h34);
        key_code = 4'h5; kc = 3'd3; key_count = kc;
        repeat (LAT + 2) tick();
        chk("jump_op_a", 32'(op_a), 32'h345);

        // Clear arriving on the same edge as a transfer wipes ovf too.
        press(4'hC); press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
        press(4'hA); press(4'h2); press(4'hF);
        check_all("pre_cx", 16'h1234, 16'h0002, 2'd0, 2'd2, 1'b1, 1'b1);
        key_code = 4'hC; kc = kc + 3'd1; key_count = kc;
        repeat (LAT - 1) tick();
        chk("cx_before_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_all("cx", 16'h0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of an issue.
        press(4'h1); press(4'hA); press(4'hF);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        check_all("rst_mid", 16'h0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (5) tick();
        check_all("post_rst", 16'h0, 16'h0, 2'd0, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
